// File: rtl/mmc_sm_insertion_scheduler_if.sv
// rtl/mmc_sm_insertion_scheduler_if.sv - request/result bundle between modulator, sorter and gate drivers
//
// Signals:
//   start  request a new selection
//   v_in   packed capacitor voltages, submodule k at [k*VW +: VW]
//   n_on   number of submodules to insert
//   i_pos  1 = charging current (insert lowest), 0 = discharging (insert highest)
//   busy   selection in progress
//   done   one-cycle pulse, gate/err valid in the same cycle
//   gate   insertion mask, bit k inserts submodule k
//   err    request rejected (over-range n_on)
// Modports: master = requester side, slave = scheduler side.

interface mmc_sm_insertion_scheduler_if #(
    parameter int N  = 5,
    parameter int VW = 12,
    parameter int CW = $clog2(N + 1)
);
    logic              start;
    logic [N*VW-1:0]   v_in;
    logic [CW-1:0]     n_on;
    logic              i_pos;
    logic              busy;
    logic              done;
    logic [N-1:0]      gate;
    logic              err;

    modport master (
        output start, v_in, n_on, i_pos,
        input  busy, done, gate, err
    );

    modport slave (
        input  start, v_in, n_on, i_pos,
        output busy, done, gate, err
    );
endinterface

// File: rtl/mmc_sm_insertion_scheduler.sv
// rtl/mmc_sm_insertion_scheduler.sv - sequential capacitor-voltage-sorting insertion scheduler for one MMC arm
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mmc_sm_insertion_scheduler_if.slave (start, v_in, n_on, i_pos in; busy, done, gate, err out)
// Parameters: N submodules, VW voltage width, CW insertion-count width.
// Option macro MMC_SORT_NCLAMP_EN: clamp n_on > N to N instead of rejecting the request with err.
//
// Each pass walks k = 0..N-1 once, tracking the best unselected submodule, and
// marks it selected at the end of the pass; n_on passes give n_on*N + 1 cycles
// from the accepting edge to done.

module mmc_sm_insertion_scheduler #(
    parameter int N  = 5,
    parameter int VW = 12,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mmc_sm_insertion_scheduler_if.slave  bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t            state, state_next;

    logic [N*VW-1:0]   v_lat;
    logic [CW-1:0]     n_lat;
    logic              pos_lat;
    logic [N-1:0]      mask;
    logic [CW-1:0]     cnt;
    logic [KW-1:0]     k;
    logic [KW-1:0]     best_idx;
    logic [VW-1:0]     best_val;
    logic              best_valid;
    logic [N-1:0]      gate_r;
    logic              done_r;
    logic              err_r;
`ifndef MMC_SORT_NCLAMP_EN
    logic              over_lat;
`endif

    logic              accept;
    logic              pass_end;
    logic              go_scan;
    logic [VW-1:0]     cur_v;
    logic              better;
    logic [KW-1:0]     sel_idx;
    logic [CW-1:0]     n_eff;

    // Request admission: a zero request always skips the scan; an over-range
    // request is either clamped or sent straight to COMMIT as an error.
    always_comb begin
        n_eff = bus.n_on;
`ifdef MMC_SORT_NCLAMP_EN
        if (bus.n_on > CW'(N))
            n_eff = CW'(N);
        go_scan = (bus.n_on != '0);
`else
        go_scan = (bus.n_on != '0) && (bus.n_on <= CW'(N));
`endif
    end

    // Candidate evaluation for the current index; strict compare keeps the
    // lowest index on ties.
    always_comb begin
        cur_v  = v_lat[int'(k)*VW +: VW];
        better = 1'b0;
        if (!mask[k]) begin
            if (!best_valid)
                better = 1'b1;
            else if (pos_lat)
                better = (cur_v < best_val);
            else
                better = (cur_v > best_val);
        end
        sel_idx = better ? k : best_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pass_end   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = go_scan ? SCAN : COMMIT;
                end
            end
            SCAN: begin
                if (k == KW'(N - 1)) begin
                    pass_end = 1'b1;
                    if (cnt + CW'(1) == n_lat)
                        state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_lat      <= '0;
            n_lat      <= '0;
            pos_lat    <= 1'b0;
            mask       <= '0;
            cnt        <= '0;
            k          <= '0;
            best_idx   <= '0;
            best_val   <= '0;
            best_valid <= 1'b0;
            gate_r     <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifndef MMC_SORT_NCLAMP_EN
            over_lat   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                v_lat      <= bus.v_in;
                n_lat      <= n_eff;
                pos_lat    <= bus.i_pos;
                mask       <= '0;
                cnt        <= '0;
                k          <= '0;
                best_valid <= 1'b0;
                err_r      <= 1'b0;
`ifndef MMC_SORT_NCLAMP_EN
                over_lat   <= (bus.n_on > CW'(N));
`endif
            end
            if (state == SCAN) begin
                if (pass_end) begin
                    mask[sel_idx] <= 1'b1;
                    cnt           <= cnt + CW'(1);
                    k             <= '0;
                    best_valid    <= 1'b0;
                end else begin
                    k <= k + KW'(1);
                    if (better) begin
                        best_idx   <= k;
                        best_val   <= cur_v;
                        best_valid <= 1'b1;
                    end
                end
            end
            if (state == COMMIT) begin
                done_r <= 1'b1;
`ifdef MMC_SORT_NCLAMP_EN
                gate_r <= mask;
`else
                // A rejected request leaves the previous gate pattern in place.
                if (over_lat)
                    err_r <= 1'b1;
                else
                    gate_r <= mask;
`endif
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.gate = gate_r;
    assign bus.err  = err_r;

endmodule

// File: doc/mmc_sm_insertion_scheduler.md
# mmc_sm_insertion_scheduler

Sequential capacitor-voltage-sorting scheduler for one MMC arm. On each start request it latches the submodule capacitor voltages, the requested insertion count and the arm-current direction. It then selects which submodules to insert: the lowest voltages when the current charges the capacitors, the highest when it discharges them. It sits between the modulator, which supplies `n_on` once per switching period, and the gate drivers, which consume `gate`.

## Interface
Parameters:
- `N`, 5, number of submodules per arm
- `VW`, 12, capacitor-voltage width (unsigned)
- `CW`, `$clog2(N+1)`, width of the insertion count

Ports:
- `clk`  in  1  system clock, all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a new selection; sampled only in IDLE
- `v_in`  in  N*VW  packed voltages; submodule k occupies bits [k*VW +: VW]
- `n_on`  in  CW  number of submodules to insert
- `i_pos`  in  1  1 = charging current (insert lowest), 0 = discharging (insert highest)
- `busy`  out  1  selection in progress
- `done`  out  1  one-cycle pulse; `gate` is valid in the same cycle
- `gate`  out  N  insertion mask; bit k = 1 inserts submodule k
- `err`  out  1  request rejected (see Configuration); valid with `done`

## Operation
- States: IDLE, SCAN, COMMIT.
- **IDLE, `start` = 1:**
  - Latch `v_in`, `n_on` and `i_pos`.
  - Clear the working mask and the selection counter. Clear `err`.
  - Go to SCAN if 0 < `n_on` ≤ N. Otherwise go to COMMIT.
- **SCAN pass:** lasts N cycles, with index k = 0..N-1, one index per cycle.
  - Only unselected submodules are candidates.
  - The candidate replaces the current best only on a strict compare: `<` when `i_pos` = 1, `>` when `i_pos` = 0.
  - Ties therefore resolve to the lowest index.
  - At k = N-1, set the best index in the working mask and increment the counter.
  - Counter = latched `n_on` → go to COMMIT. Otherwise start a new pass at k = 0.
- **COMMIT:**
  - Load `gate` from the working mask. For the over-range case, see Configuration.
  - Pulse `done` and return to IDLE.
- **Outside an operation:** `gate` holds its value between operations and is never modified outside COMMIT.
- **`start` while busy:** `start` is ignored in SCAN and COMMIT. It is not queued.
- **Input sampling:** `v_in`, `n_on` and `i_pos` are sampled only at the accepting edge. Later changes do not affect the running operation.

## Timing
- **Reset values:** `gate` = 0, `busy` = 0, `done` = 0, `err` = 0, state = IDLE. Any working mask or counter content is discarded.
- **Accepting edge E0:** `start` is sampled high in IDLE. `busy` = 1 from E0.
- **Latency to `done`:** `done` = 1 and the new `gate` appear after edge E0 + `n_on`*N + 1.
  - `n_on` = 0 or over-range: after E0 + 1.
- **End of operation:** `busy` falls at the same edge at which `done` rises. `busy` and `done` are never high together.
- **Back-to-back:** a new `start` is accepted in the cycle in which `done` = 1, because the state is IDLE.
- **Reset mid-operation:** `rst_n` low during SCAN or COMMIT immediately forces the reset values. No `done` is produced for the aborted operation.

## Configuration
- Macro: `MMC_SORT_NCLAMP_EN`.
- **Defined:** `n_on` > N is clamped to N. The operation performs N passes and yields `gate` = all ones. `err` is never asserted.
- **Undefined:** `n_on` > N goes directly to COMMIT.
  - `gate` keeps its previous value.
  - `err` = 1 together with `done`, held until the next accepted `start`.

## Test plan
All scenarios use N = 5 and VW = 12. Voltages are listed as v0..v4.

- **Charging, n_on = 2:** v = 100, 300, 200, 50, 400; `i_pos` = 1 → `gate` = 5'b01001; `done` after E0 + 11; `err` = 0.
- **Discharging, n_on = 2:** same voltages; `i_pos` = 0 → `gate` = 5'b10010; `done` after E0 + 11.
- **Ties:** all v = 500; `n_on` = 3; either `i_pos` → `gate` = 5'b00111.
- **Zero request:** `n_on` = 0 → `gate` = 0; `done` after E0 + 1.
- **Full request:** `n_on` = 5 → `gate` = 5'b11111; `done` after E0 + 26.
- **Over-range request:** previous `gate` = 5'b00011; `n_on` = 7.
  - Without the macro → `gate` stays 5'b00011; `err` = 1; `done` after E0 + 1.
  - With the macro → `gate` = 5'b11111; `err` = 0.
- **Start while busy, then reset mid-SCAN:**
  - Pulse `start` while busy → it has no effect.
  - Drop `rst_n` at E0 + 4 → `gate` = 0 and `busy` = 0 immediately; no `done` follows.
